iiitb_sipo_deser: RTL and testbench
===================================

# iiitb_sipo_deser

Serial-in, parallel-out deserializer sitting directly upstream of the 4-bit parallel register in the user project. Collects a qualified serial bit stream from an IO pad into WIDTH-bit words and presents each completed word on a parallel bus with a valid/ready handshake. Holds one completed word while the next one is being assembled, and flags lost words with an overrun indication. Clock is the Wishbone clock of the user area.

## Interface
Parameters:
- WIDTH, 4, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = first received bit lands in po[WIDTH-1]; 0 = first bit lands in po[0].

Ports:
- clk  in  1  rising-edge clock (driven from wb_clk_i).
- clear_n  in  1  reset, asynchronous assert, active-low.
- sin  in  1  serial data bit.
- sin_valid  in  1  sin is sampled on this cycle's rising edge.
- flush  in  1  synchronous: discard partial word, held word, and overrun.
- po  out  WIDTH  completed parallel word (feeds the parallel register's pi).
- po_valid  out  1  po holds an unconsumed word.
- po_ready  in  1  downstream accepts po this cycle.
- overrun  out  1  sticky: a completed word was dropped.
- bit_cnt  out  clog2(WIDTH)  bits collected in the current partial word.

## Operation
- Reset (clear_n low, any time, asynchronous): shift register = 0, bit_cnt = 0, po = 0, po_valid = 0, overrun = 0. All state is restored to these values immediately, including mid-word.
- Shift stage: on each cycle with sin_valid=1, sin is shifted in. MSB_FIRST=1 shifts left with sin entering at bit 0. MSB_FIRST=0 shifts right with sin entering at bit WIDTH-1. bit_cnt increments.
- Completion: the cycle that accepts the WIDTH-th bit (bit_cnt == WIDTH-1 and sin_valid) completes a word. On that same edge, bit_cnt wraps to 0 and the assembled word, including the current bit, is offered to the hold stage.
- Hold stage is a two-state FSM, EMPTY (po_valid=0) and FULL (po_valid=1):
  - EMPTY + completion → FULL; po loads the word.
  - FULL + po_ready, no completion → EMPTY; po keeps its last value.
  - FULL + po_ready + completion → stays FULL; po loads the new word (back-to-back transfer, no bubble).
  - FULL + no po_ready + completion → stays FULL; po unchanged. The new word is dropped and overrun is set to 1.
  - po_ready while EMPTY is ignored.
- overrun stays at 1 until flush or reset. The shift stage never stalls.
- flush=1: bit_cnt → 0, shift register → 0, po_valid → 0, overrun → 0. po keeps its value.
  - flush has priority over a simultaneous sin_valid (the bit is discarded), completion, and po_ready.
- Width rule: bit_cnt is clog2(WIDTH) bits wide and never exceeds WIDTH-1.

## Timing
- Latency: po and po_valid update on the same rising edge that samples the last bit. They are visible from the cycle after the last bit was presented.
- po must be stable whenever po_valid=1 and po_ready=0.
- A transfer happens on any edge where po_valid=1 and po_ready=1.
- Sustained throughput: one word per WIDTH sin_valid cycles, with zero loss when po_ready is held high.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package/include holds:
  - hold-stage state encodings (ST_EMPTY=1'b0, ST_FULL=1'b1);
  - default WIDTH=4, so the deserializer and the downstream parallel register agree.
- Single module, no sub-modules. Shift register, bit counter, hold FSM and overrun flag are small enough to sit together.
- Top-level wiring: sin from io_in[31], sin_valid from io_in[30], po to the parallel register's pi, po_ready tied high when the register samples every cycle.

## Test plan
- Reset mid-word: send bits 1,1 (bit_cnt=2), pulse clear_n low → bit_cnt=0, po=0, po_valid=0, overrun=0 immediately, without waiting for a clk edge.
- MSB-first assembly: WIDTH=4, po_ready=0, bits 1,0,1,1 on consecutive cycles → po=4'b1011 and po_valid=1 the cycle after the 4th bit; bit_cnt=0.
- LSB-first and gaps: MSB_FIRST=0, bits 1,0,0,0 with sin_valid low for 3 cycles between bits → po=4'b0001, completed only after the 4th valid bit.
- Back-to-back: po_ready=1, stream 0xA then 0x5 (8 continuous bits) → po=4'hA, then po=4'h5 exactly 4 cycles later, po_valid never drops, overrun=0.
- Overrun: po_ready=0, stream 0x3 then 0xC → po stays 4'h3, overrun=1 after the 8th bit; a later po_ready pulse empties the hold stage and overrun stays at 1.
- Flush priority: after 3 bits, assert flush together with sin_valid and po_ready while holding 0x3 → bit_cnt=0, po_valid=0, overrun=0; the next 4 bits 0,1,1,0 yield po=4'h6.

Source files
------------

// File: rtl/iiitb_sipo_deser_pkg.sv
// iiitb_sipo_deser_pkg
// Shared definitions for the serial-in, parallel-out deserializer and the
// downstream parallel register it feeds.
//   DEFAULT_WIDTH : word width both blocks agree on.
//   hold_state_e  : hold-stage states (EMPTY = no word offered, FULL = word offered).
package iiitb_sipo_deser_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } hold_state_e;

endpackage

// File: rtl/iiitb_sipo_deser.sv
// iiitb_sipo_deser
// Collects a qualified serial bit stream into WIDTH-bit words and offers each
// completed word on a parallel bus with a valid/ready handshake. One completed
// word is held while the next is assembled; words completed while the hold
// stage is full and not being drained are dropped and flagged by overrun.
//
// Parameters:
//   WIDTH     : word width in bits, 2..32.
//   MSB_FIRST : 1 = first received bit lands in po[WIDTH-1], 0 = in po[0].
// Ports:
//   clk       in   rising-edge clock (wb_clk_i)
//   clear_n   in   asynchronous active-low reset
//   sin       in   serial data bit (io_in[31] at the top level)
//   sin_valid in   sin is sampled on this edge (io_in[30] at the top level)
//   flush     in   synchronous discard of partial word, held word and overrun
//   po        out  completed word (to the parallel register's pi)
//   po_valid  out  po holds an unconsumed word
//   po_ready  in   downstream accepts po this cycle (tie high if it samples every cycle)
//   overrun   out  sticky: a completed word was dropped
//   bit_cnt   out  bits collected in the current partial word
module iiitb_sipo_deser
    import iiitb_sipo_deser_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b1,
    localparam int unsigned CNT_W    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             flush,
    output logic [WIDTH-1:0] po,
    output logic             po_valid,
    input  logic             po_ready,
    output logic             overrun,
    output logic [CNT_W-1:0] bit_cnt
);

    logic [WIDTH-1:0] r_shift;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [WIDTH-1:0] r_po;
    hold_state_e      r_state;
    logic             r_overrun;

    logic [WIDTH-1:0] w_shift_next;
    logic             w_complete;

    // Shift direction decides where the first bit ends up after WIDTH shifts.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shift_next = {r_shift[WIDTH-2:0], sin};
        end else begin : g_lsb_first
            assign w_shift_next = {sin, r_shift[WIDTH-1:1]};
        end
    endgenerate

    // The edge accepting the WIDTH-th bit completes a word; w_shift_next then
    // already contains that bit, so it is what the hold stage loads.
    assign w_complete = sin_valid && (r_bit_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_po      <= '0;
            r_state   <= ST_EMPTY;
            r_overrun <= 1'b0;
        end else if (flush) begin
            // po is deliberately left alone; only its validity is withdrawn.
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_state   <= ST_EMPTY;
            r_overrun <= 1'b0;
        end else begin
            // The shift stage never stalls, whatever the hold stage is doing.
            if (sin_valid) begin
                r_shift   <= w_shift_next;
                r_bit_cnt <= w_complete ? '0 : r_bit_cnt + CNT_W'(1);
            end

            case (r_state)
                ST_EMPTY: begin
                    if (w_complete) begin
                        r_state <= ST_FULL;
                        r_po    <= w_shift_next;
                    end
                end
                ST_FULL: begin
                    if (w_complete) begin
                        // Drained and refilled on the same edge: no bubble.
                        if (po_ready) begin
                            r_po <= w_shift_next;
                        end else begin
                            r_overrun <= 1'b1;
                        end
                    end else if (po_ready) begin
                        r_state <= ST_EMPTY;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    assign po       = r_po;
    assign po_valid = (r_state == ST_FULL);
    assign overrun  = r_overrun;
    assign bit_cnt  = r_bit_cnt;

endmodule

// File: tb/tb_iiitb_sipo_deser.sv
// Bench for iiitb_sipo_deser: an MSB-first and an LSB-first instance share the
// same stimulus; a word-level model predicts both and is compared every cycle,
// and directed scenarios add hand-computed literal checks.
module tb_iiitb_sipo_deser;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         clear_n = 1'b1;
    logic         sin = 1'b0;
    logic         sin_valid = 1'b0;
    logic         flush = 1'b0;
    logic         po_ready = 1'b0;

    logic [W-1:0] po_m, po_l;
    logic         po_valid_m, po_valid_l;
    logic         overrun_m, overrun_l;
    logic [1:0]   bit_cnt_m, bit_cnt_l;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    iiitb_sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk       (clk),
        .clear_n   (clear_n),
        .sin       (sin),
        .sin_valid (sin_valid),
        .flush     (flush),
        .po        (po_m),
        .po_valid  (po_valid_m),
        .po_ready  (po_ready),
        .overrun   (overrun_m),
        .bit_cnt   (bit_cnt_m)
    );

    iiitb_sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk       (clk),
        .clear_n   (clear_n),
        .sin       (sin),
        .sin_valid (sin_valid),
        .flush     (flush),
        .po        (po_l),
        .po_valid  (po_valid_l),
        .po_ready  (po_ready),
        .overrun   (overrun_l),
        .bit_cnt   (bit_cnt_l)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- word-level model ----------------
    bit           m_bits[$];     // bits of the partial word, oldest first
    logic [W-1:0] m_po_m = '0;
    logic [W-1:0] m_po_l = '0;
    bit           m_valid = 1'b0;
    bit           m_ovr = 1'b0;
    bit           m_done;
    logic [W-1:0] m_word_m, m_word_l;

    always @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            m_bits.delete();
            m_po_m  = '0;
            m_po_l  = '0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end else if (flush) begin
            m_bits.delete();
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end else begin
            m_done = 1'b0;
            if (sin_valid) begin
                m_bits.push_back(sin);
                if (m_bits.size() == W) begin
                    m_done = 1'b1;
                    for (int i = 0; i < W; i++) begin
                        m_word_m[W-1-i] = m_bits[i];
                        m_word_l[i]     = m_bits[i];
                    end
                    m_bits.delete();
                end
            end
            if (m_done) begin
                if (!m_valid || po_ready) begin
                    m_po_m  = m_word_m;
                    m_po_l  = m_word_l;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && po_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        check("po_msb",       32'(po_m),       32'(m_po_m));
        check("po_lsb",       32'(po_l),       32'(m_po_l));
        check("po_valid_msb", 32'(po_valid_m), 32'(m_valid));
        check("po_valid_lsb", 32'(po_valid_l), 32'(m_valid));
        check("overrun_msb",  32'(overrun_m),  32'(m_ovr));
        check("overrun_lsb",  32'(overrun_l),  32'(m_ovr));
        check("bit_cnt_msb",  32'(bit_cnt_m),  32'(m_bits.size()));
        check("bit_cnt_lsb",  32'(bit_cnt_l),  32'(m_bits.size()));
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic v, input logic b, input logic rdy, input logic fl);
        @(negedge clk);
        sin_valid = v;
        sin       = b;
        po_ready  = rdy;
        flush     = fl;
    endtask

    task automatic send_nibble(input logic [3:0] n, input logic rdy);
        for (int i = 3; i >= 0; i--) step(1'b1, n[i], rdy, 1'b0);
    endtask

    initial begin
        #1 clear_n = 1'b0;
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_po",      32'(po_m),       32'h0);
        check("reset_valid",   32'(po_valid_m), 32'h0);
        check("reset_overrun", 32'(overrun_m),  32'h0);
        check("reset_bit_cnt", 32'(bit_cnt_m),  32'h0);
        clear_n = 1'b1;

        // Reset mid-word, checked before any clock edge.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("midword_bit_cnt", 32'(bit_cnt_m), 32'd2);
        #2 clear_n = 1'b0;
        #1;
        check("async_bit_cnt", 32'(bit_cnt_m),  32'h0);
        check("async_po",      32'(po_m),       32'h0);
        check("async_valid",   32'(po_valid_m), 32'h0);
        check("async_overrun", 32'(overrun_m),  32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        clear_n = 1'b1;

        // MSB-first assembly: 1,0,1,1.
        send_nibble(4'b1011, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("asm_po_msb",  32'(po_m),       32'hB);
        check("asm_po_lsb",  32'(po_l),       32'hD);
        check("asm_valid",   32'(po_valid_m), 32'h1);
        check("asm_bit_cnt", 32'(bit_cnt_m),  32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("drain_valid", 32'(po_valid_m), 32'h0);

        // LSB-first with gaps: 1,0,0,0 with 3 idle cycles between bits.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, (i == 0), 1'b0, 1'b0);
            if (i == 2) begin
                step(1'b0, 1'b0, 1'b0, 1'b0);
                check("gap_not_done", 32'(po_valid_l), 32'h0);
            end
            if (i < 3) repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("gap_po_lsb", 32'(po_l),       32'h1);
        check("gap_po_msb", 32'(po_m),       32'h8);
        check("gap_valid",  32'(po_valid_l), 32'h1);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Back-to-back: 0xA then 0x5, ready on the completing edge of 0x5.
        send_nibble(4'hA, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("b2b_first", 32'(po_m), 32'hA);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("b2b_hold_valid", 32'(po_valid_m), 32'h1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("b2b_hold_valid", 32'(po_valid_m), 32'h1);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("b2b_hold_valid", 32'(po_valid_m), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("b2b_second",  32'(po_m),       32'h5);
        check("b2b_valid",   32'(po_valid_m), 32'h1);
        check("b2b_overrun", 32'(overrun_m),  32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Ready held high: every word reaches po with no loss.
        send_nibble(4'h9, 1'b1);
        send_nibble(4'h6, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("stream_po",      32'(po_m),      32'h6);
        check("stream_overrun", 32'(overrun_m), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Overrun: 0x3 then 0xC with no ready.
        send_nibble(4'h3, 1'b0);
        send_nibble(4'hC, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("ovr_po",      32'(po_m),      32'h3);
        check("ovr_flag",    32'(overrun_m), 32'h1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("ovr_drained", 32'(po_valid_m), 32'h0);
        check("ovr_sticky",  32'(overrun_m),  32'h1);

        // Flush priority: hold 0x3, 3 bits in, then flush with a valid bit and ready.
        send_nibble(4'h3, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("flush_bit_cnt", 32'(bit_cnt_m),  32'h0);
        check("flush_valid",   32'(po_valid_m), 32'h0);
        check("flush_overrun", 32'(overrun_m),  32'h0);
        check("flush_po_kept", 32'(po_m),       32'h3);
        send_nibble(4'h6, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("flush_next_po", 32'(po_m),       32'h6);
        check("flush_next_v",  32'(po_valid_m), 32'h1);

        // Mixed traffic against the model.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                 1'($urandom_range(0, 40) == 0));
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
